// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer:
// opcodes, FSM state encoding, datapath select encodings and the decode bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  // CLS_ILLEGAL must stay the zero encoding: an all-zero decode bundle means "no operation".
  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [1:0] imm_sel;
    logic [1:0] alu_sel;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] wb_sel;
  } dec_t;

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction decode: opcode/funct3/funct7[5] -> instruction class
// and datapath selects. Unsupported encodings come out as an all-zero CLS_ILLEGAL bundle.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output dec_t       dec
);

  // Class and select decode; anything not recognised collapses to zeros.
  always_comb begin
    dec = '0;
    case (opcode)
      OP_R: begin
        dec.cls    = CLS_ALU;
        dec.wb_sel = WB_ALU;
        case ({funct3, funct7_5})
          4'b000_0: dec.alu_sel = ALU_ADD;
          4'b000_1: dec.alu_sel = ALU_SUB;
          4'b111_0: dec.alu_sel = ALU_AND;
          4'b110_0: dec.alu_sel = ALU_OR;
          default:  dec.cls     = CLS_ILLEGAL;
        endcase
      end
      OP_I: begin
        dec.cls    = CLS_ALU;
        dec.b_sel  = 1'b1;
        dec.wb_sel = WB_ALU;
        case (funct3)
          3'b000:  dec.alu_sel = ALU_ADD;
          3'b111:  dec.alu_sel = ALU_AND;
          3'b110:  dec.alu_sel = ALU_OR;
          default: dec.cls     = CLS_ILLEGAL;
        endcase
      end
      OP_LOAD: begin
        dec.cls    = (funct3 == 3'b010) ? CLS_LOAD : CLS_ILLEGAL;
        dec.b_sel  = 1'b1;
        dec.wb_sel = WB_MEM;
      end
      OP_STORE: begin
        dec.cls     = (funct3 == 3'b010) ? CLS_STORE : CLS_ILLEGAL;
        dec.imm_sel = IMM_S;
        dec.b_sel   = 1'b1;
      end
      OP_BRANCH: begin
        dec.cls     = (funct3 == 3'b000) ? CLS_BRANCH : CLS_ILLEGAL;
        dec.imm_sel = IMM_B;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
      end
      OP_JAL: begin
        dec.cls     = CLS_JUMP;
        dec.imm_sel = IMM_J;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        dec.cls    = (funct3 == 3'b000) ? CLS_JUMP : CLS_ILLEGAL;
        dec.b_sel  = 1'b1;
        dec.wb_sel = WB_PC4;
      end
      default: dec.cls = CLS_ILLEGAL;
    endcase
    if (dec.cls == CLS_ILLEGAL) dec = '0;
  end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle control sequencer for the 32-bit RISC-V datapath.
// Optional build macro ILLEGAL_TRAP_EN: when defined, an unsupported instruction
// sets err and halts in DECODE; otherwise it retires as a NOP from EXEC.
//
//   state  | meaning
//   FETCH  | latch instruction word into ir
//   DECODE | classify ir (trap on illegal when enabled)
//   EXEC   | drive ALU selects; branch and NOP retire here
//   MEM    | hold mem_req until mem_ready or timeout; store retires here
//   WB     | register write, PC update, retire
//   HALT   | memory timeout / illegal trap; left only by reset
module riscv_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inst,
  input  logic             BEQ,
  input  logic             mem_ready,
  output logic [1:0]       Imm_sel,
  output logic [1:0]       Alu_sel,
  output logic             A_sel,
  output logic             B_sel,
  output logic             Pc_sel,
  output logic             pc_en,
  output logic             Reg_we,
  output logic             Mem_we,
  output logic             mem_req,
  output logic [1:0]       Wb_Sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             err
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [TW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  dec_t             dec;
  logic             unused_ir;

  // Only opcode, funct3 and funct7[5] steer control; the rest belongs to the datapath.
  assign unused_ir = ^{ir_q[WIDTH-1:31], ir_q[29:15], ir_q[11:7]};

  riscv_ctrl_decode u_decode (
    .opcode   (ir_q[6:0]),
    .funct3   (ir_q[14:12]),
    .funct7_5 (ir_q[30]),
    .dec      (dec)
  );

  assign err     = err_q;
  assign instret = instret_q;

  // State, instruction, wait timer, error flag and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and per-phase outputs; selects are held for EXEC through WB.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    err_d     = err_q;
    instret_d = instret_q;
    Imm_sel   = 2'b00;
    Alu_sel   = 2'b00;
    A_sel     = 1'b0;
    B_sel     = 1'b0;
    Pc_sel    = 1'b0;
    pc_en     = 1'b0;
    Reg_we    = 1'b0;
    Mem_we    = 1'b0;
    mem_req   = 1'b0;
    Wb_Sel    = 2'b00;
    retire    = 1'b0;

    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      Imm_sel = dec.imm_sel;
      Alu_sel = dec.alu_sel;
      A_sel   = dec.a_sel;
      B_sel   = dec.b_sel;
      Wb_Sel  = dec.wb_sel;
      Pc_sel  = (dec.cls == CLS_JUMP);
    end

    case (state_q)
      ST_FETCH: begin
        ir_d    = inst;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        if (dec.cls == CLS_ILLEGAL) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
`else
        state_d = ST_EXEC;
`endif
      end
      ST_EXEC: begin
        case (dec.cls)
          CLS_LOAD, CLS_STORE: begin
            // Down-counter: terminal count 0 marks the last permitted MEM cycle.
            wait_d  = TW'(MEM_TIMEOUT - 1);
            state_d = ST_MEM;
          end
          CLS_BRANCH: begin
            pc_en   = 1'b1;
            Pc_sel  = BEQ;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CLS_ILLEGAL: begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        Mem_we  = (dec.cls == CLS_STORE);
        if (mem_ready) begin
          if (dec.cls == CLS_STORE) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_q == '0) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ST_WB: begin
        Reg_we  = 1'b1;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase

    if (retire) instret_d = instret_q + 1'b1;
  end

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed bench for riscv_ctrl_fsm: hand-encoded instructions with expected
// latencies and select values. Honours ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_riscv_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        BEQ;
  logic        mem_ready;
  logic [1:0]  Imm_sel, Alu_sel, Wb_Sel;
  logic        A_sel, B_sel, Pc_sel, pc_en, Reg_we, Mem_we, mem_req, retire, err;
  logic [31:0] instret;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_ORI  = 32'h00506093;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_SLL  = 32'h002091B3;

  riscv_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .BEQ       (BEQ),
    .mem_ready (mem_ready),
    .Imm_sel   (Imm_sel),
    .Alu_sel   (Alu_sel),
    .A_sel     (A_sel),
    .B_sel     (B_sel),
    .Pc_sel    (Pc_sel),
    .pc_en     (pc_en),
    .Reg_we    (Reg_we),
    .Mem_we    (Mem_we),
    .mem_req   (mem_req),
    .Wb_Sel    (Wb_Sel),
    .retire    (retire),
    .instret   (instret),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int exp_ret = 0;

  int   r_cyc, r_memc, r_rwe, r_mwe;
  logic r_done;
  logic s_pc_en, s_pc_sel, s_reg_we, s_mem_we, s_mem_req, s_a_sel, s_b_sel;
  logic [1:0] s_imm, s_alu, s_wb;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start at a falling edge with the DUT in FETCH; walk until retire (bounded).
  // mem_ready is raised in the MEM cycle that follows `waits` stalled MEM cycles.
  task automatic run_instr(input logic [31:0] iw, input logic beq, input int waits);
    inst = iw; BEQ = beq; mem_ready = 1'b0;
    r_cyc = 0; r_memc = 0; r_rwe = 0; r_mwe = 0; r_done = 1'b0;
    while (!r_done && r_cyc < 40) begin
      r_cyc++;
      mem_ready = mem_req && (r_memc == waits);
      #1;
      if (mem_req) r_memc++;
      if (Reg_we)  r_rwe++;
      if (Mem_we)  r_mwe++;
      if (retire) begin
        r_done = 1'b1;
        s_pc_en = pc_en;   s_pc_sel = Pc_sel;  s_reg_we = Reg_we;
        s_mem_we = Mem_we; s_mem_req = mem_req;
        s_a_sel = A_sel;   s_b_sel = B_sel;
        s_imm = Imm_sel;   s_alu = Alu_sel;    s_wb = Wb_Sel;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    check_eq("retired_within_bound", r_done, 1'b1);
    if (r_done) exp_ret++;
  endtask

  int memc, rets, err_at;

  initial begin
    rst_n = 1'b1; inst = '0; BEQ = 1'b0; mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs",
             {Imm_sel, Alu_sel, A_sel, B_sel, Pc_sel, pc_en, Reg_we, Mem_we, mem_req, Wb_Sel, retire, err}, '0);
    check_eq("reset_instret", instret, 0);
    rst_n = 1'b1;

    // add x3,x1,x2
    run_instr(I_ADD, 1'b0, 0);
    check_eq("add_cycles", r_cyc, 4);
    check_eq("add_wb", {s_reg_we, s_pc_en, s_pc_sel, s_alu, s_wb, s_b_sel}, {1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0});
    check_eq("add_instret", instret, exp_ret);

    run_instr(I_SUB, 1'b0, 0);
    check_eq("sub_alu", {s_alu, s_wb}, {2'b01, 2'b01});
    run_instr(I_AND, 1'b0, 0);
    check_eq("and_alu", s_alu, 2'b10);
    run_instr(I_ORI, 1'b0, 0);
    check_eq("ori_sel", {s_alu, s_b_sel, s_imm, s_wb}, {2'b11, 1'b1, 2'b00, 2'b01});

    // lw x5,8(x1) with two wait cycles
    run_instr(I_LW, 1'b0, 2);
    check_eq("lw_cycles", r_cyc, 7);
    check_eq("lw_mem_cycles", r_memc, 3);
    check_eq("lw_mem_we", r_mwe, 0);
    check_eq("lw_wb", {s_reg_we, s_wb, s_pc_sel, s_mem_req}, {1'b1, 2'b00, 1'b0, 1'b0});

    // sw, ready in the first MEM cycle and then after one wait
    run_instr(I_SW, 1'b0, 0);
    check_eq("sw_cycles", r_cyc, 4);
    check_eq("sw_retire", {s_mem_we, s_mem_req, s_pc_en, s_pc_sel, s_imm}, {1'b1, 1'b1, 1'b1, 1'b0, 2'b01});
    check_eq("sw_no_reg_we", r_rwe, 0);
    run_instr(I_SW, 1'b0, 1);
    check_eq("sw_wait_cycles", r_cyc, 5);
    check_eq("sw_wait_mem_we", r_mwe, 2);

    // beq taken / not taken
    run_instr(I_BEQ, 1'b1, 0);
    check_eq("beq_t_cycles", r_cyc, 3);
    check_eq("beq_t_sel", {s_pc_en, s_pc_sel, s_a_sel, s_b_sel, s_imm, s_alu}, {1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00});
    check_eq("beq_t_reg_we", r_rwe, 0);
    run_instr(I_BEQ, 1'b0, 0);
    check_eq("beq_nt_cycles", r_cyc, 3);
    check_eq("beq_nt_pc_sel", {s_pc_en, s_pc_sel}, {1'b1, 1'b0});

    // jumps
    run_instr(I_JAL, 1'b0, 0);
    check_eq("jal_cycles", r_cyc, 4);
    check_eq("jal_wb", {s_reg_we, s_wb, s_pc_sel, s_a_sel, s_imm}, {1'b1, 2'b10, 1'b1, 1'b1, 2'b11});
    run_instr(I_JALR, 1'b0, 0);
    check_eq("jalr_wb", {s_wb, s_pc_sel, s_a_sel, s_b_sel, s_imm}, {2'b10, 1'b1, 1'b0, 1'b1, 2'b00});
    check_eq("instret_after_mix", instret, exp_ret);

    // sw with mem_ready never asserted: 16 MEM cycles then HALT
    inst = I_SW; mem_ready = 1'b0; memc = 0; rets = 0; err_at = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mem_req) memc++;
      if (retire) rets++;
      if (err && err_at < 0) err_at = i;
      @(negedge clk);
    end
    check_eq("timeout_mem_cycles", memc, 16);
    check_eq("timeout_err_cycle", err_at, 19);
    check_eq("timeout_no_retire", rets, 0);
    check_eq("halt_enables", {err, pc_en, Reg_we, Mem_we, mem_req, retire}, {1'b1, 5'b0});
    check_eq("halt_instret", instret, exp_ret);
    rst_n = 1'b0;
    #1;
    check_eq("reset_clears_err", {err, instret}, 33'b0);
    exp_ret = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // reset during WB of jal aborts it
    inst = I_JAL;
    repeat (3) @(negedge clk);
    #1;
    check_eq("jal_in_wb", {Reg_we, retire}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_eq("abort_no_pulse", {Reg_we, retire, pc_en}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_instret", instret, 0);
    run_instr(I_ADD, 1'b0, 0);
    check_eq("after_abort_add_cycles", r_cyc, 4);
    check_eq("after_abort_instret", instret, exp_ret);

    // illegal opcode
`ifdef ILLEGAL_TRAP_EN
    inst = I_ILL; rets = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (retire) rets++;
      @(negedge clk);
    end
    check_eq("ill_trap", {err, pc_en, retire}, 3'b100);
    check_eq("ill_no_retire", rets, 0);
    check_eq("ill_instret", instret, exp_ret);
`else
    run_instr(I_ILL, 1'b0, 0);
    check_eq("ill_cycles", r_cyc, 3);
    check_eq("ill_nop", {s_pc_en, s_pc_sel, s_reg_we, s_mem_we, s_mem_req}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    check_eq("ill_no_writes", {r_rwe[7:0], r_mwe[7:0]}, 16'h0);
    run_instr(I_SLL, 1'b0, 0);
    check_eq("sll_nop_cycles", r_cyc, 3);
    check_eq("ill_err_clear", err, 1'b0);
    check_eq("ill_instret", instret, exp_ret);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
